// File: rtl/fitness_pkg.sv
// Shared types for the fitness tracker display path: mode encoding, sequencer
// FSM states and the BCD digit-adjust step used by the binary-to-BCD converter.
// No ports; imported by bin2bcd_seq and stat_display_sequencer.
package fitness_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_STEPS = 2'd0;
    localparam mode_t MODE_DIST  = 2'd1;
    localparam mode_t MODE_O32   = 2'd2;
    localparam mode_t MODE_HAT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CONV = 2'd2
    } state_t;

    // Double-dabble correction: any digit of 5 or more gets +3 so that the
    // following left shift carries correctly into the next decade.
    function automatic logic [15:0] add3_digits(input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (d[i*4 +: 4] >= 4'd5) ? d[i*4 +: 4] + 4'd3 : d[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary to 4-digit BCD converter, one bit per clock.
// Latency: start sampled at edge S, result final at edge S+VAL_W; done flags the last step.
// No backpressure: start is only issued while idle; reset aborts a conversion.
// Ports: clk, reset (async, active-high), start, bin[VAL_W-1:0] -> busy, done, bcd[15:0].
module bin2bcd_seq
    import fitness_pkg::*;
#(
    parameter int VAL_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] sh;
    logic [15:0]      acc;
    logic [15:0]      adj;
    logic [CNT_W-1:0] cnt;

    assign adj = add3_digits(acc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            sh   <= bin;
            acc  <= '0;
            cnt  <= CNT_W'(VAL_W);
            busy <= 1'b1;
        end else if (busy) begin
            acc <= {adj[14:0], sh[VAL_W-1]};
            sh  <= sh << 1;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    // High during the final shift; bcd holds the finished result from the
    // following clock until the next start.
    assign done = busy && (cnt == CNT_W'(1));
    assign bcd  = acc;

endmodule

// File: rtl/stat_display_sequencer.sv
// Rotates the 7-seg display among four tracker statistics, snapshots, clamps and BCD-converts the chosen one.
// Latency: tick_1s sampled at edge N -> bcd/dp/sat/disp_valid update at edge N+VAL_W+2.
// No backpressure: ticks arriving mid-conversion collapse into a single pending refresh.
// Ports: clk, reset, tick_1s, hold, total_steps, distance_t, over32_sec, hat -> mode, bcd, dp, sat, disp_valid.
module stat_display_sequencer
    import fitness_pkg::*;
#(
    parameter int DWELL_SEC = 2,
    parameter int SAT_VALUE = 9999,
    parameter int VAL_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1s,
    input  logic             hold,
    input  logic [VAL_W-1:0] total_steps,
    input  logic [VAL_W-1:0] distance_t,
    input  logic [VAL_W-1:0] over32_sec,
    input  logic [VAL_W-1:0] hat,
    output logic [1:0]       mode,
    output logic [15:0]      bcd,
    output logic [3:0]       dp,
    output logic             sat,
    output logic             disp_valid
);

    state_t           state, next_state;
    logic             pending;
    logic [3:0]       dwell;
    logic [VAL_W-1:0] stat_sel;
    logic [VAL_W-1:0] conv_bin;
    logic             over_sat;
    logic             sat_n;
    logic             snap_dist;
    logic             upd;
    logic             conv_start;
    logic             conv_busy;
    logic             conv_done;
    logic [15:0]      conv_bcd;

    always_comb begin
        stat_sel = total_steps;
        case (mode)
            MODE_STEPS: stat_sel = total_steps;
            MODE_DIST:  stat_sel = distance_t;
            MODE_O32:   stat_sel = over32_sec;
            MODE_HAT:   stat_sel = hat;
            default:    stat_sel = total_steps;
        endcase
    end

    // The converter latches the clamped value on the same edge that leaves LOAD,
    // so the clamp feeds it directly rather than through a register.
    assign over_sat = stat_sel > VAL_W'(SAT_VALUE);
    assign conv_bin = over_sat ? VAL_W'(SAT_VALUE) : stat_sel;

    always_comb begin
        next_state = state;
        conv_start = 1'b0;
        case (state)
            ST_IDLE: if (tick_1s || pending) next_state = ST_LOAD;
            ST_LOAD: begin
                conv_start = !conv_busy;
                next_state = ST_CONV;
            end
            ST_CONV: if (conv_done) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= 1'b0;
            dwell      <= '0;
            mode       <= MODE_STEPS;
            sat_n      <= 1'b0;
            snap_dist  <= 1'b0;
            upd        <= 1'b0;
            bcd        <= '0;
            dp         <= '0;
            sat        <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            if (state == ST_IDLE && next_state == ST_LOAD) begin
                pending <= 1'b0;
            end else if (tick_1s && state != ST_IDLE) begin
                pending <= 1'b1;
            end

            // Rotation runs in every FSM state so a tick's mode change is
            // already visible when its own refresh reaches LOAD.
            if (tick_1s && !hold) begin
                if (dwell == 4'(DWELL_SEC - 1)) begin
                    dwell <= '0;
                    mode  <= mode + 2'd1;
                end else begin
                    dwell <= dwell + 4'd1;
                end
            end

            if (state == ST_LOAD) begin
                sat_n     <= over_sat;
                snap_dist <= (mode == MODE_DIST);
            end

            // done marks the last shift; the result is captured one clock later
            // so the FSM can already be back in IDLE and start the next refresh.
            upd <= conv_done;
            if (upd) begin
                bcd        <= conv_bcd;
                dp         <= snap_dist ? 4'b0010 : 4'b0000;
                sat        <= sat_n;
                disp_valid <= 1'b1;
            end
        end
    end

    bin2bcd_seq #(.VAL_W(VAL_W)) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

endmodule

// File: tb/tb_stat_display_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed expected displays, a monitor
// pops and compares whenever the sequencer commits a new conversion.
module tb_stat_display_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_1s;
    logic        hold;
    logic [15:0] total_steps, distance_t, over32_sec, hat;
    logic [1:0]  mode;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        sat, disp_valid;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        sat;
        logic [1:0]  mode;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    stat_display_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1s     (tick_1s),
        .hold        (hold),
        .total_steps (total_steps),
        .distance_t  (distance_t),
        .over32_sec  (over32_sec),
        .hat         (hat),
        .mode        (mode),
        .bcd         (bcd),
        .dp          (dp),
        .sat         (sat),
        .disp_valid  (disp_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Returns the index of the edge that samples the pulse.
    task automatic tick_pulse(output int t0);
        @(negedge clk);
        tick_1s = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        tick_1s = 1'b0;
    endtask

    task automatic push(input logic [15:0] b, input logic [3:0] d, input logic s,
                        input logic [1:0] m, input int c);
        exp_t e;
        e.bcd = b; e.dp = d; e.sat = s; e.mode = m; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80 && sbq.size() != 0; i++) @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending_expected=%0d required=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic send(input logic [15:0] b, input logic [3:0] d, input logic s, input logic [1:0] m);
        int t0;
        tick_pulse(t0);
        push(b, d, s, m, t0 + 18);
        wait_drain();
        repeat (3) @(negedge clk);
    endtask

    // Monitor: upd seen at a falling edge means the outputs commit on the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dut.upd === 1'b1) begin
                @(negedge clk);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_update bcd=%0h required=no_update", bcd);
                end else begin
                    e = sbq.pop_front();
                    chk("bcd", bcd, e.bcd);
                    chk("dp", dp, e.dp);
                    chk("sat", sat, e.sat);
                    chk("mode", mode, e.mode);
                    chk("disp_valid", disp_valid, 1);
                    chk("update_edge", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2;
        reset = 1'b1; tick_1s = 1'b0; hold = 1'b0;
        total_steps = '0; distance_t = '0; over32_sec = '0; hat = '0;
        repeat (3) @(negedge clk);
        chk("rst_mode", mode, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_dp", dp, 0);
        chk("rst_sat", sat, 0);
        chk("rst_valid", disp_valid, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Rotation with DWELL_SEC=2: modes 0,1,1,2,2,3,3,0
        total_steps = 16'd1234;  send(16'h1234, 4'b0000, 1'b0, 2'd0);
        distance_t  = 16'd57;    send(16'h0057, 4'b0010, 1'b0, 2'd1);
        distance_t  = 16'd999;   send(16'h0999, 4'b0010, 1'b0, 2'd1);
        over32_sec  = 16'd250;   send(16'h0250, 4'b0000, 1'b0, 2'd2);
        over32_sec  = 16'd9999;  send(16'h9999, 4'b0000, 1'b0, 2'd2);
        hat         = 16'd12000; send(16'h9999, 4'b0000, 1'b1, 2'd3);
        hat         = 16'd42;    send(16'h0042, 4'b0000, 1'b0, 2'd3);
        total_steps = 16'd10000; send(16'h9999, 4'b0000, 1'b1, 2'd0);

        // Ticks during a conversion: one merged extra refresh; mode already 1 at both commits.
        total_steps = 16'd5;
        tick_pulse(t0);
        push(16'h0005, 4'b0000, 1'b0, 2'd1, t0 + 18);
        push(16'h0123, 4'b0010, 1'b0, 2'd1, t0 + 36);
        repeat (4) @(negedge clk);
        distance_t = 16'd123;
        tick_pulse(t1);
        repeat (2) @(negedge clk);
        hold = 1'b1;
        tick_pulse(t2);
        hold = 1'b0;
        wait_drain();
        repeat (40) @(negedge clk);

        distance_t = 16'd450; send(16'h0450, 4'b0010, 1'b0, 2'd1);
        over32_sec = 16'd7;   send(16'h0007, 4'b0000, 1'b0, 2'd2);

        // hold: mode frozen at 2 while the value keeps refreshing
        hold = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            logic [3:0] d;
            d = 4'(i);
            over32_sec = 16'(1111 * i);
            send({d, d, d, d}, 4'b0000, 1'b0, 2'd2);
        end
        hold = 1'b0;

        // Reset 8 clocks into a conversion: outputs clear at once, conversion aborted
        over32_sec = 16'd4321;
        tick_pulse(t0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_bcd", bcd, 0);
        chk("midrst_valid", disp_valid, 0);
        chk("midrst_mode", mode, 0);
        chk("midrst_dp", dp, 0);
        chk("midrst_sat", sat, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("postrst_valid", disp_valid, 0);

        total_steps = 16'd808; send(16'h0808, 4'b0000, 1'b0, 2'd0);
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
